crypto_wallet_pio_out_blink: RTL and testbench

- Parametrised successor to the fixed 8-bit LED output PIO: an Avalon-MM slave driving WIDTH output bits.
- Adds atomic bit set/clear registers, a per-bit blink enable, and a programmable blink half-period counter.
- Sits on the Nios II data master's peripheral bus and drives board LEDs or other slow status outputs.
- Readback has zero wait states and zero latency, matching the existing PIO slaves.

---
 rtl/crypto_wallet_pio_pkg.sv | 19 +
 rtl/crypto_wallet_pio_out_blink_if.sv | 36 +++
 rtl/crypto_wallet_blink_timer.sv | 50 +++++
 rtl/crypto_wallet_pio_out_blink.sv | 102 ++++++++++
 tb/tb_crypto_wallet_pio_out_blink.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/crypto_wallet_pio_pkg.sv
// ---------------------------------------------------------------------------
// crypto_wallet_pio_pkg
// Shared definitions for the blinking output PIO: Avalon word-address map of
// the register file and the bit position of the phase flag in STATUS.
// ---------------------------------------------------------------------------
package crypto_wallet_pio_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_DATA     = 3'd0;
    localparam addr_t ADDR_BLINK_EN = 3'd1;
    localparam addr_t ADDR_PERIOD   = 3'd2;
    localparam addr_t ADDR_STATUS   = 3'd3;
    localparam addr_t ADDR_OUTSET   = 3'd4;
    localparam addr_t ADDR_OUTCLEAR = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/crypto_wallet_pio_out_blink_if.sv
// ---------------------------------------------------------------------------
// crypto_wallet_pio_out_blink_if
// Avalon-MM slave bus of the blinking output PIO (zero wait states, zero
// read latency, so there is no read strobe or waitrequest).
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data
// ---------------------------------------------------------------------------
interface crypto_wallet_pio_out_blink_if;
    import crypto_wallet_pio_pkg::*;

    addr_t       address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/crypto_wallet_blink_timer.sv
// ---------------------------------------------------------------------------
// crypto_wallet_blink_timer
// Free-running half-period counter. Counts 0..period, then wraps and toggles
// phase, so each phase lasts period+1 cycles. A restart forces cnt=0 and
// phase=1 ("on" half) and wins over a simultaneous terminal count.
//   clk, reset  clock, synchronous active-high reset
//   period      half-period terminal count
//   restart     reload request (PERIOD register write)
//   phase       registered blink phase, 1 = on
//   phase_next  value phase takes on the next edge (for output registering)
// ---------------------------------------------------------------------------
module crypto_wallet_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase,
    output logic                phase_next
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    always_comb begin
        cnt_d      = cnt_q + PERIOD_W'(1);
        phase_next = phase;
        if (restart) begin
            cnt_d      = '0;
            phase_next = 1'b1;
        end else if (cnt_q == period) begin
            cnt_d      = '0;
            phase_next = ~phase;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            phase <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            phase <= phase_next;
        end
    end

endmodule

// File: rtl/crypto_wallet_pio_out_blink.sv
// ---------------------------------------------------------------------------
// crypto_wallet_pio_out_blink
// WIDTH-bit output PIO with atomic set/clear, per-bit blink enable and a
// programmable blink half-period.
//   clk      system clock
//   reset    synchronous active-high reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata,
//            readdata)
//   out_port registered output pins
// Register map: 0 DATA, 1 BLINK_EN, 2 PERIOD, 3 STATUS (bit0 = phase),
// 4 OUTSET (WO), 5 OUTCLEAR (WO), 6..7 reserved.
// ---------------------------------------------------------------------------
module crypto_wallet_pio_out_blink
    import crypto_wallet_pio_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               PERIOD_W     = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int unsigned      PERIOD_RESET = 12499999
) (
    input  logic                          clk,
    input  logic                          reset,
    crypto_wallet_pio_out_blink_if.slave  bus,
    output logic [WIDTH-1:0]              out_port
);

    localparam logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_W'(PERIOD_RESET);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    blink_en_q, blink_en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [WIDTH-1:0]    wdata;
    logic                wr;
    logic                restart;
    logic                phase;
    logic                phase_next;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wdata   = bus.writedata[WIDTH-1:0];
    assign restart = wr && (bus.address == ADDR_PERIOD);

    // Upper writedata bits are deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    crypto_wallet_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .period     (period_q),
        .restart    (restart),
        .phase      (phase),
        .phase_next (phase_next)
    );

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:     data_d     = wdata;
                ADDR_BLINK_EN: blink_en_d = wdata;
                ADDR_PERIOD:   period_d   = bus.writedata[PERIOD_W-1:0];
                ADDR_OUTSET:   data_d     = data_q | wdata;
                ADDR_OUTCLEAR: data_d     = data_q & ~wdata;
                default:       ;
            endcase
        end
    end

    // out_port is computed from next-state values so the pins move exactly one
    // edge after the write or toggle, with no bus-to-pin combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= PERIOD_INIT;
            out_port   <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            out_port   <= data_d & ~(blink_en_d & {WIDTH{~phase_next}});
        end
    end

    // NOTE: every output of this always_comb is assigned a default first, so no
    // address value can leave readdata unassigned and infer a latch.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:     bus.readdata = 32'(data_q);
            ADDR_BLINK_EN: bus.readdata = 32'(blink_en_q);
            ADDR_PERIOD:   bus.readdata = 32'(period_q);
            ADDR_STATUS:   bus.readdata[STATUS_PHASE_BIT] = phase;
            default:       ;
        endcase
    end

endmodule

// File: tb/tb_crypto_wallet_pio_out_blink.sv
// ---------------------------------------------------------------------------
// tb_crypto_wallet_pio_out_blink
// Self-checking bench: register/decode vectors from a table, hand-written
// blink, period-boundary and mid-blink reset sequences. Expected out_port
// values go through a scoreboard queue and are checked after the edge.
// ---------------------------------------------------------------------------
module tb_crypto_wallet_pio_out_blink;
    import crypto_wallet_pio_pkg::*;

    localparam logic [7:0]  RV      = 8'hA5;
    localparam logic [31:0] PER_RST = 32'd12499999;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] out_port;

    crypto_wallet_pio_out_blink_if bus ();

    crypto_wallet_pio_out_blink #(
        .WIDTH        (8),
        .PERIOD_W     (24),
        .RESET_VALUE  (RV),
        .PERIOD_RESET (12499999)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [2:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
        logic [2:0]  rd_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        check(name, bus.readdata, exp);
    endtask

    // Pops the expected out_port pushed before the edge and compares it.
    task automatic sb_check(input string name);
        if (sb_q.size() == 0) begin
            check({name, " (scoreboard empty)"}, 32'h1, 32'h0);
        end else begin
            check(name, {24'h0, out_port}, {24'h0, sb_q.pop_front()});
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [7:0] exp_out,
                            input string name);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        sb_q.push_back(exp_out);
        tick();
        bus_idle();
        sb_check(name);
    endtask

    // Phase k edges after a restart edge (k=0 is the restart edge itself).
    function automatic logic exp_phase(input int k, input int p);
        return ((k / (p + 1)) % 2) == 0;
    endfunction

    // With DATA=FF and BLINK_EN=81, bits 7 and 0 follow phase.
    function automatic logic [7:0] blink_out(input logic ph);
        return ph ? 8'hFF : 8'h7E;
    endfunction

    task automatic blink_run(input int k0, input int k1, input int p, input string tag);
        for (int k = k0; k <= k1; k++) begin
            if (k > k0) begin
                sb_q.push_back(blink_out(exp_phase(k, p)));
                tick();
                sb_check($sformatf("%s out k=%0d", tag, k));
            end
            read_check($sformatf("%s status k=%0d", tag, k), ADDR_STATUS, {31'h0, exp_phase(k, p)});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr cs    wr_n  wdata          exp_out rd  exp_rd
        vecs[0]  = '{3'd0, 1'b1, 1'b0, 32'h0000_000F, 8'h0F, 3'd0, 32'h0F};
        vecs[1]  = '{3'd4, 1'b1, 1'b0, 32'h0000_00F0, 8'hFF, 3'd0, 32'hFF};
        vecs[2]  = '{3'd5, 1'b1, 1'b0, 32'h0000_003C, 8'hC3, 3'd0, 32'hC3};
        vecs[3]  = '{3'd3, 1'b1, 1'b0, 32'h0000_00FF, 8'hC3, 3'd3, 32'h01};
        vecs[4]  = '{3'd6, 1'b1, 1'b0, 32'h0000_00FF, 8'hC3, 3'd6, 32'h00};
        vecs[5]  = '{3'd7, 1'b1, 1'b0, 32'h0000_0000, 8'hC3, 3'd7, 32'h00};
        vecs[6]  = '{3'd0, 1'b0, 1'b0, 32'h0000_0000, 8'hC3, 3'd0, 32'hC3};
        vecs[7]  = '{3'd0, 1'b1, 1'b1, 32'h0000_0000, 8'hC3, 3'd0, 32'hC3};
        vecs[8]  = '{3'd4, 1'b1, 1'b0, 32'hFFFF_FF00, 8'hC3, 3'd4, 32'h00};
        vecs[9]  = '{3'd5, 1'b0, 1'b0, 32'h0000_00FF, 8'hC3, 3'd5, 32'h00};
        vecs[10] = '{3'd1, 1'b1, 1'b0, 32'h0000_0000, 8'hC3, 3'd1, 32'h00};
        vecs[11] = '{3'd0, 1'b1, 1'b0, 32'h0000_0155, 8'h55, 3'd0, 32'h55};

        // Reset for two cycles.
        bus_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset out_port", {24'h0, out_port}, {24'h0, RV});
        read_check("reset DATA", ADDR_DATA, {24'h0, RV});
        read_check("reset PERIOD", ADDR_PERIOD, PER_RST);
        read_check("reset STATUS", ADDR_STATUS, 32'h1);
        read_check("reset BLINK_EN", ADDR_BLINK_EN, 32'h0);

        // Register map, set/clear and decode vectors.
        for (int i = 0; i < 12; i++) begin
            bus.address    = vecs[i].addr;
            bus.chipselect = vecs[i].cs;
            bus.write_n    = vecs[i].wr_n;
            bus.writedata  = vecs[i].wdata;
            sb_q.push_back(vecs[i].exp_out);
            tick();
            bus_idle();
            sb_check($sformatf("vec%0d out_port", i));
            read_check($sformatf("vec%0d readdata", i), vecs[i].rd_addr, vecs[i].exp_rd);
        end

        // Blink with PERIOD=3: four cycles on, four cycles off.
        do_write(ADDR_DATA, 32'hFF, 8'hFF, "blink set DATA");
        do_write(ADDR_BLINK_EN, 32'h81, 8'hFF, "blink set BLINK_EN");
        read_check("BLINK_EN readback", ADDR_BLINK_EN, 32'h81);
        do_write(ADDR_PERIOD, 32'hFF00_0003, 8'hFF, "blink set PERIOD");
        read_check("PERIOD readback", ADDR_PERIOD, 32'h3);
        blink_run(0, 17, 3, "p3");

        // PERIOD=0: phase toggles every cycle.
        do_write(ADDR_PERIOD, 32'h0, 8'hFF, "p0 set PERIOD");
        blink_run(0, 5, 0, "p0");

        // PERIOD write exactly on the terminal-count edge restarts the "on" half.
        do_write(ADDR_PERIOD, 32'h3, 8'hFF, "tc set PERIOD");
        blink_run(0, 3, 3, "tc pre");
        do_write(ADDR_PERIOD, 32'h3, 8'hFF, "tc rewrite on terminal");
        blink_run(0, 9, 3, "tc post");

        // Reset while phase=0, with a competing DATA write in the same cycle.
        do_write(ADDR_PERIOD, 32'h3, 8'hFF, "rst set PERIOD");
        blink_run(0, 5, 3, "rst pre");
        reset          = 1'b1;
        bus.address    = ADDR_DATA;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = 32'h00;
        tick();
        reset = 1'b0;
        bus_idle();
        check("mid reset out_port", {24'h0, out_port}, {24'h0, RV});
        read_check("mid reset STATUS", ADDR_STATUS, 32'h1);
        read_check("mid reset BLINK_EN", ADDR_BLINK_EN, 32'h0);
        read_check("mid reset DATA", ADDR_DATA, {24'h0, RV});
        read_check("mid reset PERIOD", ADDR_PERIOD, PER_RST);
        tick();
        check("post reset out_port", {24'h0, out_port}, {24'h0, RV});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
